iprf_wb_arbiter: RTL

- Parametrised writeback arbiter between FU_NUM functional-unit writeback sources and WBPORT_NUM integer physical-regfile and ROB writeback ports.
- Replaces the fixed one-to-one FU-to-write-port wiring in the execution block.
- Each FU has a small skid FIFO. Heads are granted round-robin onto a narrower set of write ports.
- Buffered entries younger than a squash point are discarded.

---
 rtl/iprf_wb_arbiter_pkg.sv | 35 +++
 rtl/iprf_wb_arbiter_if.sv | 44 ++++
 rtl/iprf_wb_arbiter_fu_wb_fifo.sv | 74 +++++++
 rtl/iprf_wb_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/iprf_wb_arbiter_pkg.sv
// rtl/iprf_wb_arbiter_pkg.sv - shared types, widths and age compare for the writeback arbiter
// Purpose: ROB index and writeback request types, default sizing, rob_younger().
// Ports: none (package).
package iprf_wb_arbiter_pkg;

  localparam int IPHYREG_NUM    = 128;
  localparam int ROB_SIZE       = 64;
  localparam int WBPORT_NUM_DEF = 4;

  localparam int IPR_WID        = $clog2(IPHYREG_NUM);
  localparam int ROB_WID        = $clog2(ROB_SIZE);
  localparam int DEF_WBPORT_NUM = WBPORT_NUM_DEF;

  localparam int XLEN          = 64;
  localparam int DEF_FU_NUM    = 6;
  localparam int DEF_BUF_DEPTH = 2;

  typedef struct packed {
    logic               flag;
    logic [ROB_WID-1:0] idx;
  } robIdx_t;

  typedef struct packed {
    logic               rd_wen;
    logic [IPR_WID-1:0] iprd;
    logic [XLEN-1:0]    result;
    robIdx_t            robIdx;
  } wbReq_t;

  // a is younger than b; the wrap flag flips the sense of the index compare
  function automatic logic rob_younger(input robIdx_t a, input robIdx_t b);
    return (a.flag == b.flag) ? (a.idx > b.idx) : (a.idx < b.idx);
  endfunction

endpackage

// File: rtl/iprf_wb_arbiter_if.sv
// rtl/iprf_wb_arbiter_if.sv - FU writeback / squash / write-port bundle for the arbiter
// Purpose: groups FU requests, squash and write-port outputs.
// Ports (signals): i_squash_vld, i_squash_robIdx, i_fu_vld, o_fu_ready, i_fu_rd_wen,
//   i_fu_iprd, i_fu_result, i_fu_robIdx, o_wb_vld, o_wb_rd_wen, o_wb_iprd,
//   o_wb_result, o_wb_robIdx, o_wb_fuId. slave = arbiter side, master = FU/regfile side.
interface iprf_wb_arbiter_if #(
  parameter int FU_NUM     = iprf_wb_arbiter_pkg::DEF_FU_NUM,
  parameter int WBPORT_NUM = iprf_wb_arbiter_pkg::DEF_WBPORT_NUM
);
  import iprf_wb_arbiter_pkg::*;

  localparam int FU_ID_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  localparam int RB_W    = ROB_WID + 1;

  logic                          i_squash_vld;
  robIdx_t                       i_squash_robIdx;
  logic [FU_NUM-1:0]             i_fu_vld;
  logic [FU_NUM-1:0]             o_fu_ready;
  logic [FU_NUM-1:0]             i_fu_rd_wen;
  logic [FU_NUM*IPR_WID-1:0]     i_fu_iprd;
  logic [FU_NUM*XLEN-1:0]        i_fu_result;
  logic [FU_NUM*RB_W-1:0]        i_fu_robIdx;
  logic [WBPORT_NUM-1:0]         o_wb_vld;
  logic [WBPORT_NUM-1:0]         o_wb_rd_wen;
  logic [WBPORT_NUM*IPR_WID-1:0] o_wb_iprd;
  logic [WBPORT_NUM*XLEN-1:0]    o_wb_result;
  logic [WBPORT_NUM*RB_W-1:0]    o_wb_robIdx;
  logic [WBPORT_NUM*FU_ID_W-1:0] o_wb_fuId;

  modport slave (
    input  i_squash_vld, i_squash_robIdx, i_fu_vld, i_fu_rd_wen, i_fu_iprd,
           i_fu_result, i_fu_robIdx,
    output o_fu_ready, o_wb_vld, o_wb_rd_wen, o_wb_iprd, o_wb_result,
           o_wb_robIdx, o_wb_fuId
  );

  modport master (
    output i_squash_vld, i_squash_robIdx, i_fu_vld, i_fu_rd_wen, i_fu_iprd,
           i_fu_result, i_fu_robIdx,
    input  o_fu_ready, o_wb_vld, o_wb_rd_wen, o_wb_iprd, o_wb_result,
           o_wb_robIdx, o_wb_fuId
  );

endinterface

// File: rtl/iprf_wb_arbiter_fu_wb_fifo.sv
// rtl/iprf_wb_arbiter_fu_wb_fifo.sv - per-FU skid FIFO with squash kill bits
// Purpose: circular buffer of writeback requests; squashed entries are marked and
//   drained from the head one per cycle without being offered to the arbiter.
// Ports: clk, rst_n (async active-low), squash_vld/squash_robIdx, push/push_data,
//   pop (arbiter grant), head/head_vld (live head), count.
module fu_wb_fifo
  import iprf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             squash_vld,
  input  robIdx_t          squash_robIdx,
  input  logic             push,
  input  wbReq_t           push_data,
  input  logic             pop,
  output wbReq_t           head,
  output logic             head_vld,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wbReq_t           mem [DEPTH];
  logic [DEPTH-1:0] kill;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             head_kill;
  logic             push_eff;
  logic             pop_eff;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  // A head caught by this cycle's squash must not be granted in the same cycle.
  assign head_kill = kill[rd_ptr] || (squash_vld && rob_younger(head.robIdx, squash_robIdx));
  assign head_vld  = !empty && !head_kill;
  // A push younger than a concurrent squash is accepted from the FU but dropped.
  assign push_eff  = push && !(squash_vld && rob_younger(push_data.robIdx, squash_robIdx));
  assign pop_eff   = !empty && (head_kill || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      kill   <= '0;
    end else begin
      if (squash_vld) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rob_younger(mem[i].robIdx, squash_robIdx)) kill[i] <= 1'b1;
        end
      end
      if (push_eff) begin
        kill[wr_ptr] <= 1'b0;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop_eff) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push_eff) - CNT_W'(pop_eff);
    end
  end

  // Payload storage needs no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/iprf_wb_arbiter.sv
// rtl/iprf_wb_arbiter.sv - round-robin writeback arbiter from FU FIFOs onto regfile/ROB write ports
// Purpose: buffers FU writebacks per FU and grants up to WBPORT_NUM live heads per
//   cycle, scanning from rr_ptr; all write-port outputs are registered.
// Ports: clk, rst (async active-low), wb_if (slave modport of iprf_wb_arbiter_if).
module iprf_wb_arbiter
  import iprf_wb_arbiter_pkg::*;
#(
  parameter int FU_NUM     = DEF_FU_NUM,
  parameter int WBPORT_NUM = DEF_WBPORT_NUM,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
  input logic               clk,
  input logic               rst,
  iprf_wb_arbiter_if.slave  wb_if
);

  localparam int FU_ID_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  localparam int CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam int RB_W    = ROB_WID + 1;

  wbReq_t            fu_req   [FU_NUM];
  wbReq_t            head     [FU_NUM];
  logic [CNT_W-1:0]  count    [FU_NUM];
  logic [FU_NUM-1:0] head_vld;
  logic [FU_NUM-1:0] grant;
  logic [FU_NUM-1:0] fu_ready;
  logic [FU_NUM-1:0] push;

  logic [FU_ID_W-1:0]            rr_ptr;
  logic [FU_ID_W-1:0]            rr_next;
  logic [WBPORT_NUM-1:0]         wb_vld_d;
  logic [WBPORT_NUM-1:0]         wb_rd_wen_d;
  logic [WBPORT_NUM*IPR_WID-1:0] wb_iprd_d;
  logic [WBPORT_NUM*XLEN-1:0]    wb_result_d;
  logic [WBPORT_NUM*RB_W-1:0]    wb_robIdx_d;
  logic [WBPORT_NUM*FU_ID_W-1:0] wb_fuId_d;

  assign wb_if.o_fu_ready = fu_ready;

  for (genvar f = 0; f < FU_NUM; f++) begin : g_fifo
    assign fu_req[f] = {wb_if.i_fu_rd_wen[f],
                        wb_if.i_fu_iprd[f*IPR_WID +: IPR_WID],
                        wb_if.i_fu_result[f*XLEN +: XLEN],
                        wb_if.i_fu_robIdx[f*RB_W +: RB_W]};
    // Ready looks only at the registered count, so a full FIFO refuses even when it pops.
    assign fu_ready[f] = (count[f] < CNT_W'(BUF_DEPTH));
    assign push[f]     = wb_if.i_fu_vld[f] && fu_ready[f];

    fu_wb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk          (clk),
      .rst_n        (rst),
      .squash_vld   (wb_if.i_squash_vld),
      .squash_robIdx(wb_if.i_squash_robIdx),
      .push         (push[f]),
      .push_data    (fu_req[f]),
      .pop          (grant[f]),
      .head         (head[f]),
      .head_vld     (head_vld[f]),
      .count        (count[f])
    );
  end

  // Scan FUs from rr_ptr, filling ports 0,1,... in scan order.
  always_comb begin
    int n;
    int f;
    n           = 0;
    f           = 0;
    grant       = '0;
    rr_next     = rr_ptr;
    wb_vld_d    = '0;
    wb_rd_wen_d = '0;
    wb_iprd_d   = '0;
    wb_result_d = '0;
    wb_robIdx_d = '0;
    wb_fuId_d   = '0;
    for (int k = 0; k < FU_NUM; k++) begin
      f = int'(rr_ptr) + k;
      if (f >= FU_NUM) f = f - FU_NUM;
      if (head_vld[f] && (n < WBPORT_NUM)) begin
        grant[f]                          = 1'b1;
        wb_vld_d[n]                       = 1'b1;
        wb_rd_wen_d[n]                    = head[f].rd_wen;
        wb_iprd_d[n*IPR_WID +: IPR_WID]   = head[f].iprd;
        wb_result_d[n*XLEN +: XLEN]       = head[f].result;
        wb_robIdx_d[n*RB_W +: RB_W]       = head[f].robIdx;
        wb_fuId_d[n*FU_ID_W +: FU_ID_W]   = FU_ID_W'(f);
        rr_next = (f == FU_NUM - 1) ? '0 : FU_ID_W'(f + 1);
        n = n + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr            <= '0;
      wb_if.o_wb_vld    <= '0;
      wb_if.o_wb_rd_wen <= '0;
      wb_if.o_wb_iprd   <= '0;
      wb_if.o_wb_result <= '0;
      wb_if.o_wb_robIdx <= '0;
      wb_if.o_wb_fuId   <= '0;
    end else begin
      rr_ptr            <= rr_next;
      wb_if.o_wb_vld    <= wb_vld_d;
      wb_if.o_wb_rd_wen <= wb_rd_wen_d;
      wb_if.o_wb_iprd   <= wb_iprd_d;
      wb_if.o_wb_result <= wb_result_d;
      wb_if.o_wb_robIdx <= wb_robIdx_d;
      wb_if.o_wb_fuId   <= wb_fuId_d;
    end
  end

endmodule
